pmem_responder: RTL and testbench

Memory-side responder for the core's load/store port: a single-outstanding request/response slave that owns a 64-bit-wide data SRAM. It answers core load/store requests over a valid/ready handshake, using a fixed programmable latency. It sits between the core's data port and on-chip storage, replacing per-cycle DPI access with a cycle-accurate memory model.

---
 rtl/pmem_responder_if.sv | 25 ++
 rtl/pmem_responder.sv | 134 +++++++++++++
 tb/tb_pmem_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_responder_if.sv
// Load/store port between the core's data side and the memory responder.
// Carries one request channel and one response channel, each valid/ready.
// The master is the core side; the slave is the responder.
interface pmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_we;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pmem_responder.sv
// Single-outstanding load/store responder that owns a 2^DEPTH_LOG2 x 64-bit SRAM.
// Latency: response valid LATENCY edges after request acceptance (1..15).
// Backpressure: response held frozen until rsp_ready; PMEM_RESPONDER_FWD_EN lets a new request be accepted on the response handshake.
module pmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input logic              clk,
  input logic              rst,
  pmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        ready;
  logic        accept;
  logic        access;

  logic [63:0] addr_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;

  logic [63:0] rdata_q;
  logic        err_q;

  // Storage deliberately has no reset so contents survive rst.
  logic [63:0] mem [DEPTH];

  // Word index is taken from the 64-bit offset; anything above the array wraps
  // into the upper offset bits and is flagged as an error instead.
  logic [63:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_offset_lsb;

  assign offset            = addr_q - BASE;
  assign in_range          = (offset >> (DEPTH_LOG2 + 3)) == 64'd0;
  assign idx               = offset[DEPTH_LOG2+2:3];
  assign unused_offset_lsb = ^offset[2:0];

  // Next-state, countdown and request-ready decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
`ifdef PMEM_RESPONDER_FWD_EN
          ready = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      ready = 1'b0;
    end
    accept = bus.req_valid && ready;
    if (accept) begin
      state_next = WAIT;
      cnt_next   = 4'(LATENCY - 1);
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request at acceptance; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
    end
  end

  // Response registers: loaded at the access point, cleared on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q   <= !in_range;
      rdata_q <= (in_range && !we_q) ? mem[idx] : 64'd0;
    end else if (state == RESP && bus.rsp_ready) begin
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end
  end

  // Byte-masked store; an access cut off by rst is never performed.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder with a response scoreboard.
// Expected responses and acceptance edges are queued at issue and checked when rsp_valid rises.
// Runs the load/store, error, backpressure, reset and throughput scenarios.
module tb_pmem_responder;
  localparam int LATENCY = 2;
`ifdef PMEM_RESPONDER_FWD_EN
  localparam int SPACING = LATENCY + 1;
`else
  localparam int SPACING = LATENCY + 2;
`endif

  localparam logic [63:0] W0   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W1P  = 64'h1122_3344_AAAA_AAAA;
  localparam logic [63:0] WTOP = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pmem_responder_if bus();

  pmem_responder #(
    .DEPTH_LOG2(10),
    .BASE(64'h0000_0000_8000_0000),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   acc_q[$];
  logic prev_valid = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any newly raised response.
  task automatic tick();
    rsp_t e;
    int   a;
    @(negedge clk);
    if (bus.rsp_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      assert (exp_q.size() != 0 && acc_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_rsp observed=rsp_valid_high expected=no_response cyc=%0d", cyc);
      end
      if (exp_q.size() != 0 && acc_q.size() != 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        chk("rsp_latency", 64'(cyc), 64'(a + LATENCY));
      end
    end
    prev_valid = bus.rsp_valid;
  endtask

  // Present a request until it is accepted; returns with req_valid dropped.
  task automatic issue(input logic [63:0] a, input logic we, input logic [63:0] wd,
                       input logic [7:0] wm, input logic [63:0] er, input logic ee,
                       input bit track, output int acc);
    bit   done = 1'b0;
    rsp_t r;
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_wdata = wd;
    bus.req_wmask = wm;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (bus.req_ready === 1'b1) begin
        acc  = cyc + 1;
        done = 1'b1;
        if (track) begin
          r.rdata = er;
          r.err   = ee;
          exp_q.push_back(r);
          acc_q.push_back(acc);
        end
      end
      tick();
    end
    bus.req_valid = 1'b0;
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL accept_timeout observed=no_accept expected=accept addr=%h", a);
    end
  endtask

  // Wait for the response and let the handshake edge pass (rsp_ready must be 1).
  task automatic finish_rsp();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) done = 1'b1;
      tick();
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL rsp_timeout observed=no_rsp expected=rsp cyc=%0d", cyc);
    end
  endtask

  task automatic txn(input logic [63:0] a, input logic we, input logic [63:0] wd,
                     input logic [7:0] wm, input logic [63:0] er, input logic ee);
    int acc;
    issue(a, we, wd, wm, er, ee, 1'b1, acc);
    finish_rsp();
  endtask

  initial begin
    int          acc;
    int          acc_t[4];
    logic [63:0] ta[4];
    logic [63:0] te[4];
    bit          seen;

    bus.req_valid = 1'b0;
    bus.req_addr  = 64'd0;
    bus.req_we    = 1'b0;
    bus.req_wdata = 64'd0;
    bus.req_wmask = 8'd0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;

    // Reset state.
    repeat (3) tick();
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_req_ready", 64'(bus.req_ready), 64'd1);

    // Seed word 0, full-mask store then load.
    txn(64'h8000_0000, 1'b1, W0, 8'hFF, 64'd0, 1'b0);
    txn(64'h8000_0008, 1'b1, W1, 8'hFF, 64'd0, 1'b0);
    txn(64'h8000_0008, 1'b0, 64'd0, 8'h00, W1, 1'b0);

    // Partial mask with ignored low address bits.
    txn(64'h8000_000D, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0);
    txn(64'h8000_0008, 1'b0, 64'd0, 8'h00, W1P, 1'b0);

    // Last valid word.
    txn(64'h8000_1FF8, 1'b1, WTOP, 8'hFF, 64'd0, 1'b0);
    txn(64'h8000_1FF8, 1'b0, 64'd0, 8'h00, WTOP, 1'b0);

    // Errors below and just above the window; word 0 must be untouched.
    txn(64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1);
    txn(64'h8000_2000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1);
    txn(64'h8000_0000, 1'b0, 64'd0, 8'h00, W0, 1'b0);

    // Zero-mask store completes and writes nothing.
    txn(64'h8000_0008, 1'b1, 64'h0, 8'h00, 64'd0, 1'b0);
    txn(64'h8000_0008, 1'b0, 64'd0, 8'h00, W1P, 1'b0);

    // Backpressure: response frozen, stray request ignored.
    bus.rsp_ready = 1'b0;
    issue(64'h8000_0008, 1'b0, 64'd0, 8'h00, W1P, 1'b0, 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("bp_rsp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.req_addr  = 64'h8000_0000;
        bus.req_we    = 1'b1;
        bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.req_wmask = 8'hFF;
        bus.req_valid = 1'b1;
      end
      #1;
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, W1P);
      tick();
      bus.req_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_after_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_after_rdata", bus.rsp_rdata, 64'd0);
    txn(64'h8000_0000, 1'b0, 64'd0, 8'h00, W0, 1'b0);

    // Reset while the store is in WAIT: abandoned, not performed.
    issue(64'h8000_0000, 1'b1, 64'h5, 8'hFF, 64'd0, 1'b0, 1'b0, acc);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_after_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    txn(64'h8000_0000, 1'b0, 64'd0, 8'h00, W0, 1'b0);

    // Throughput: back-to-back loads.
    ta[0] = 64'h8000_0000; te[0] = W0;
    ta[1] = 64'h8000_0008; te[1] = W1P;
    ta[2] = 64'h8000_1FF8; te[2] = WTOP;
    ta[3] = 64'h8000_0008; te[3] = W1P;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], 1'b0, 64'd0, 8'h00, te[i], 1'b0, 1'b1, acc_t[i]);
    end
    finish_rsp();
    for (int i = 1; i < 4; i++) begin
      chk("tput_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'(SPACING));
    end
    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
